// File: rtl/rr_hold_arbiter.sv
// Round-robin arbiter with multi-cycle ownership and a bounded hold limit.
// All outputs are flops; req_i only feeds the next-state logic.
module rr_hold_arbiter #(
   parameter int N        = 32,
   parameter int MAX_HOLD = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req_i,
   output logic [N-1:0]         gnt_o,
   output logic                 gnt_valid_o,
   output logic [$clog2(N)-1:0] gnt_id_o,
   output logic                 preempt_o
);
   localparam int PW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
   localparam logic [HW-1:0] HONE = HW'(1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_n;
   logic [PW-1:0]   owner, owner_n;
   logic [PW-1:0]   ptr, ptr_n;
   logic [HW-1:0]   hold_cnt, hold_n;
   logic            preempt_n;
   logic [N-1:0]    gnt_n;
   logic [PW-1:0]   id_n;
   logic            valid_n;

   logic [N-1:0]    cand;
   logic [PW-1:0]   win, win_nxt;
   logic            win_vld;
   logic            own_req, at_limit;
   int              idx;

   assign own_req  = (state == GRANT) && req_i[owner];
   assign at_limit = own_req && (hold_cnt == HMAX);

   // At the hold limit the current owner is masked out of the scan.
   always_comb begin
      cand = req_i;
      if (at_limit) cand[owner] = 1'b0;
      win     = '0;
      win_vld = 1'b0;
      idx     = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!win_vld && cand[idx]) begin
            win_vld = 1'b1;
            win     = PW'(idx);
         end
      end
      win_nxt = (win == PW'(N - 1)) ? '0 : win + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         owner       <= '0;
         ptr         <= '0;
         hold_cnt    <= '0;
         gnt_o       <= '0;
         gnt_valid_o <= 1'b0;
         gnt_id_o    <= '0;
         preempt_o   <= 1'b0;
      end else begin
         state       <= state_n;
         owner       <= owner_n;
         ptr         <= ptr_n;
         hold_cnt    <= hold_n;
         gnt_o       <= gnt_n;
         gnt_valid_o <= valid_n;
         gnt_id_o    <= id_n;
         preempt_o   <= preempt_n;
      end
   end

   always_comb begin
      state_n   = state;
      owner_n   = owner;
      ptr_n     = ptr;
      hold_n    = hold_cnt;
      preempt_n = 1'b0;
      case (state)
         IDLE: begin
            if (win_vld) begin
               state_n = GRANT;
               owner_n = win;
               ptr_n   = win_nxt;
               hold_n  = HONE;
            end
         end
         GRANT: begin
            if (!own_req) begin
               // Release: hand straight over, or fall idle with ptr kept.
               if (win_vld) begin
                  owner_n = win;
                  ptr_n   = win_nxt;
                  hold_n  = HONE;
               end else begin
                  state_n = IDLE;
                  owner_n = '0;
                  hold_n  = '0;
               end
            end else if (!at_limit) begin
               hold_n = hold_cnt + HONE;
            end else if (win_vld) begin
               owner_n   = win;
               ptr_n     = win_nxt;
               hold_n    = HONE;
               preempt_n = 1'b1;
            end else begin
               hold_n = HONE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      gnt_n   = '0;
      id_n    = '0;
      valid_n = 1'b0;
      if (state_n == GRANT) begin
         gnt_n[owner_n] = 1'b1;
         id_n           = owner_n;
         valid_n        = 1'b1;
      end
   end

endmodule
